dsp_mac_pipe: RTL



---
 rtl/dsp_mac_pkg.sv | 13 +
 rtl/dsp_mac_pipe_if.sv | 27 ++
 rtl/dsp_mac_preadd.sv | 39 +++
 rtl/dsp_mac_pipe.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - opmode bit indices and width helper shared by the MAC pipeline
package dsp_mac_pkg;

   localparam int OP_PRE_SUB  = 0;
   localparam int OP_PRE_BYP  = 1;
   localparam int OP_POST_SUB = 2;
   localparam int OP_ACC      = 3;

   function automatic int max_w(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - sample/result bus of the MAC pipeline
interface dsp_mac_pipe_if #(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int D_W = 18,
   parameter int C_W = 48,
   parameter int P_W = 48
);
   logic           in_valid;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic [D_W-1:0] d;
   logic [C_W-1:0] c;
   logic [3:0]     opmode;
   logic           out_valid;
   logic [P_W-1:0] p;

   modport master (
      output in_valid, a, b, d, c, opmode,
      input  out_valid, p
   );

   modport slave (
      input  in_valid, a, b, d, c, opmode,
      output out_valid, p
   );
endinterface

// File: rtl/dsp_mac_preadd.sv
// rtl/dsp_mac_preadd.sv - stage-2 pre-adder (d+b, d-b or b bypass), wraps modulo 2^PRE_W
module dsp_mac_preadd #(
   parameter int B_W   = 18,
   parameter int D_W   = 18,
   parameter int PRE_W = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [B_W-1:0]   b_i,
   input  logic [D_W-1:0]   d_i,
   input  logic             pre_sub_i,
   input  logic             pre_byp_i,
   output logic [PRE_W-1:0] pre_o
);

   logic [PRE_W-1:0] pre_d;
   logic [PRE_W-1:0] pre_q;

   always_comb begin
      pre_d = PRE_W'(d_i) + PRE_W'(b_i);
      if (pre_byp_i) begin
         pre_d = PRE_W'(b_i);
      end else if (pre_sub_i) begin
         pre_d = PRE_W'(d_i) - PRE_W'(b_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (ce) begin
         pre_q <= pre_d;
      end
   end

   assign pre_o = pre_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 4-stage pre-add/multiply/post-add MAC; DSP_MAC_SATURATE_EN clamps stage 4
module dsp_mac_pipe
   import dsp_mac_pkg::*;
#(
   parameter int A_W = 18,
   parameter int B_W = 18,
   parameter int D_W = 18,
   parameter int C_W = 48,
   parameter int P_W = 48
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   dsp_mac_pipe_if.slave  bus
);

   localparam int PRE_W = max_w(B_W, D_W) + 1;
   localparam int M_W   = PRE_W + A_W;
   localparam int R_W   = max_w(P_W, M_W) + 1;

   // stage 1: input registers
   logic           v1_q;
   logic [A_W-1:0] a1_q;
   logic [B_W-1:0] b1_q;
   logic [D_W-1:0] d1_q;
   logic [C_W-1:0] c1_q;
   logic [3:0]     op1_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         a1_q  <= '0;
         b1_q  <= '0;
         d1_q  <= '0;
         c1_q  <= '0;
         op1_q <= '0;
      end else if (ce) begin
         v1_q  <= bus.in_valid;
         a1_q  <= bus.a;
         b1_q  <= bus.b;
         d1_q  <= bus.d;
         c1_q  <= bus.c;
         op1_q <= bus.opmode;
      end
   end

   // stage 2: pre-adder plus the operands that ride alongside it
   logic [PRE_W-1:0] pre2;
   logic             v2_q;
   logic [A_W-1:0]   a2_q;
   logic [C_W-1:0]   c2_q;
   logic             psub2_q;
   logic             acc2_q;

   dsp_mac_preadd #(
      .B_W   (B_W),
      .D_W   (D_W),
      .PRE_W (PRE_W)
   ) u_preadd (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .b_i       (b1_q),
      .d_i       (d1_q),
      .pre_sub_i (op1_q[OP_PRE_SUB]),
      .pre_byp_i (op1_q[OP_PRE_BYP]),
      .pre_o     (pre2)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         a2_q    <= '0;
         c2_q    <= '0;
         psub2_q <= 1'b0;
         acc2_q  <= 1'b0;
      end else if (ce) begin
         v2_q    <= v1_q;
         a2_q    <= a1_q;
         c2_q    <= c1_q;
         psub2_q <= op1_q[OP_POST_SUB];
         acc2_q  <= op1_q[OP_ACC];
      end
   end

   // stage 3: full-width product
   logic [M_W-1:0] m_d;
   logic [M_W-1:0] m3_q;
   logic           v3_q;
   logic [C_W-1:0] c3_q;
   logic           psub3_q;
   logic           acc3_q;

   assign m_d = M_W'(pre2) * M_W'(a2_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m3_q    <= '0;
         v3_q    <= 1'b0;
         c3_q    <= '0;
         psub3_q <= 1'b0;
         acc3_q  <= 1'b0;
      end else if (ce) begin
         m3_q    <= m_d;
         v3_q    <= v2_q;
         c3_q    <= c2_q;
         psub3_q <= psub2_q;
         acc3_q  <= acc2_q;
      end
   end

   // stage 4: post-adder; p_q is the only feedback point, so accumulate chains need no forwarding
   logic [P_W-1:0] p_q;
   logic [P_W-1:0] p_d;
   logic           ov_q;
   logic [R_W-1:0] z;
   logic [R_W-1:0] m_ext;

   assign z     = acc3_q ? R_W'(p_q) : R_W'(c3_q);
   assign m_ext = R_W'(m3_q);

`ifdef DSP_MAC_SATURATE_EN
   logic [R_W-1:0] sum;
   logic           under;

   assign sum   = z + m_ext;
   assign under = z < m_ext;

   always_comb begin
      p_d = p_q;
      if (v3_q) begin
         if (psub3_q) begin
            p_d = under ? '0 : P_W'(z - m_ext);
         end else begin
            p_d = (|sum[R_W-1:P_W]) ? '1 : sum[P_W-1:0];
         end
      end
   end
`else
   always_comb begin
      p_d = p_q;
      if (v3_q) begin
         p_d = psub3_q ? P_W'(z - m_ext) : P_W'(z + m_ext);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q  <= '0;
         ov_q <= 1'b0;
      end else if (ce) begin
         p_q  <= p_d;
         ov_q <= v3_q;
      end
   end

   assign bus.p         = p_q;
   assign bus.out_valid = ov_q;

endmodule
